// File: rtl/sobel_window_filter.sv
// sobel_window_filter: pipelined 3x3 window filter that turns one window per
// valid cycle into one 8-bit pixel. The pixel is either a Sobel gradient
// magnitude (optionally binarised) or a box blur. The block also tracks the
// output position so it can raise end-of-line and end-of-frame pulses.
module sobel_window_filter #(
  parameter int LINE_WIDTH      = 512,
  parameter int LINES_PER_FRAME = 510,
  parameter int THRESHOLD       = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        input_pixel_valid,
  input  logic [71:0] pixel_window,
  input  logic        filter_mode,
  output logic [7:0]  output_pixel,
  output logic        output_pixel_valid,
  output logic        line_done,
  output logic        frame_done
);

  typedef enum logic {MODE_SOBEL = 1'b0, MODE_BLUR = 1'b1} mode_e;

  localparam logic [8:0]  COL_LAST  = 9'(LINE_WIDTH - 1);
  localparam logic [8:0]  LINE_LAST = 9'(LINES_PER_FRAME - 1);
  // The magnitude never exceeds 2040, so clamping the level to 11 bits keeps
  // the comparison exact.
  localparam logic [10:0] THR       = (THRESHOLD > 2047) ? 11'd2047 : 11'(THRESHOLD);
  localparam bit          THR_EN    = (THRESHOLD != 0);

  // Unpack the row-major window: p[0]=p00 ... p[8]=p22.
  logic [7:0] p [9];
  always_comb begin
    for (int i = 0; i < 9; i++) p[i] = pixel_window[71 - 8*i -: 8];
  end

  // ---------------------------------------------------------------- mode latch
  logic [8:0] in_col;
  mode_e      mode_hold;
  mode_e      mode_eff;

  // The first window of a line takes the live mode; the rest of the line reuses it.
  assign mode_eff = (in_col == 9'd0) ? mode_e'(filter_mode) : mode_hold;

  // Input column counter and the per-line mode register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state is always written with <= so every register
      // samples the pre-edge values, independent of statement order.
      in_col    <= '0;
      mode_hold <= MODE_SOBEL;
    end else if (input_pixel_valid) begin
      in_col <= (in_col == COL_LAST) ? 9'd0 : in_col + 9'd1;
      if (in_col == 9'd0) mode_hold <= mode_e'(filter_mode);
    end
  end

  // ---------------------------------------------------------------- pipeline
  logic        s1_valid, s2_valid, s3_valid;
  mode_e       s1_mode, s2_mode;
  logic [9:0]  s1_left, s1_right, s1_top, s1_bot;
  logic [9:0]  s1_row0, s1_row1, s1_row2;
  logic [9:0]  s2_abs_gx, s2_abs_gy;
  logic [11:0] s2_sum;
  logic [7:0]  s3_pixel;

  logic signed [10:0] gx, gy;
  logic [10:0]        mag;
  logic [7:0]         sobel_px, blur_px, s3_next;

  assign gx  = $signed({1'b0, s1_right}) - $signed({1'b0, s1_left});
  assign gy  = $signed({1'b0, s1_bot})   - $signed({1'b0, s1_top});
  assign mag = {1'b0, s2_abs_gx} + {1'b0, s2_abs_gy};

  // Final pixel: saturated or binarised magnitude, or blur sum * 57 / 512.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    sobel_px = (mag > 11'd255) ? 8'd255 : mag[7:0];
    if (THR_EN) sobel_px = (mag >= THR) ? 8'hFF : 8'h00;
    blur_px  = 8'(({5'b0, s2_sum} * 17'd57) >> 9);
    s3_next  = (s2_mode == MODE_BLUR) ? blur_px : sobel_px;
  end

  // Valid and mode bits move down the pipeline on every clock, bubbles included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s1_mode  <= MODE_SOBEL;
      s2_mode  <= MODE_SOBEL;
    end else begin
      s1_valid <= input_pixel_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
      s1_mode  <= mode_eff;
      s2_mode  <= s1_mode;
    end
  end

  // Datapath stages S1 (partial sums), S2 (differences/abs, blur total), S3 (pixel).
  // NOTE: datapath registers carry no reset; the reset valid bits already
  // mark their contents as meaningless until fresh data arrives.
  always_ff @(posedge clk) begin
    s1_left   <= {2'b0, p[0]} + {1'b0, p[3], 1'b0} + {2'b0, p[6]};
    s1_right  <= {2'b0, p[2]} + {1'b0, p[5], 1'b0} + {2'b0, p[8]};
    s1_top    <= {2'b0, p[0]} + {1'b0, p[1], 1'b0} + {2'b0, p[2]};
    s1_bot    <= {2'b0, p[6]} + {1'b0, p[7], 1'b0} + {2'b0, p[8]};
    s1_row0   <= {2'b0, p[0]} + {2'b0, p[1]} + {2'b0, p[2]};
    s1_row1   <= {2'b0, p[3]} + {2'b0, p[4]} + {2'b0, p[5]};
    s1_row2   <= {2'b0, p[6]} + {2'b0, p[7]} + {2'b0, p[8]};
    s2_abs_gx <= gx[10] ? 10'(-gx) : gx[9:0];
    s2_abs_gy <= gy[10] ? 10'(-gy) : gy[9:0];
    s2_sum    <= {2'b0, s1_row0} + {2'b0, s1_row1} + {2'b0, s1_row2};
    s3_pixel  <= s3_next;
  end

  // ---------------------------------------------------------------- output
  logic [8:0] out_col;
  logic [8:0] line_cnt;

  // Output registers plus column/line tracking for the framing pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      output_pixel       <= '0;
      output_pixel_valid <= 1'b0;
      line_done          <= 1'b0;
      frame_done         <= 1'b0;
      out_col            <= '0;
      line_cnt           <= '0;
    end else begin
      output_pixel_valid <= s3_valid;
      line_done          <= 1'b0;
      frame_done         <= 1'b0;
      if (s3_valid) begin
        output_pixel <= s3_pixel;
        if (out_col == COL_LAST) begin
          out_col   <= '0;
          line_done <= 1'b1;
          if (line_cnt == LINE_LAST) begin
            line_cnt   <= '0;
            frame_done <= 1'b1;
          end else begin
            line_cnt <= line_cnt + 9'd1;
          end
        end else begin
          out_col <= out_col + 9'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_filter.sv
// tb_sobel_window_filter: drives two filter instances (binarisation off and
// THRESHOLD=64) with directed and random windows and compares every output
// cycle against a queue of pixels predicted from the filter equations.
module tb_sobel_window_filter;

  localparam int LW   = 16;
  localparam int LPF  = 4;
  localparam int THR1 = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        input_pixel_valid = 1'b0;
  logic [71:0] pixel_window = '0;
  logic        filter_mode = 1'b0;
  logic [7:0]  px0, px1;
  logic        v0, v1, ld0, ld1, fd0, fd1;

  always #5 clk = ~clk;

  sobel_window_filter #(.LINE_WIDTH(LW), .LINES_PER_FRAME(LPF), .THRESHOLD(0)) dut (
    .clk(clk), .rst(rst), .input_pixel_valid(input_pixel_valid),
    .pixel_window(pixel_window), .filter_mode(filter_mode),
    .output_pixel(px0), .output_pixel_valid(v0), .line_done(ld0), .frame_done(fd0));

  sobel_window_filter #(.LINE_WIDTH(LW), .LINES_PER_FRAME(LPF), .THRESHOLD(THR1)) dut_thr (
    .clk(clk), .rst(rst), .input_pixel_valid(input_pixel_valid),
    .pixel_window(pixel_window), .filter_mode(filter_mode),
    .output_pixel(px1), .output_pixel_valid(v1), .line_done(ld1), .frame_done(fd1));

  typedef struct {
    bit       v;
    bit [7:0] p0;
    bit [7:0] p1;
    bit       ld;
    bit       fd;
  } exp_t;

  exp_t     q[$];
  int       n_assert = 0;
  int       n_fail   = 0;
  int       m_in_col, m_out_col, m_line;
  bit       m_mode;
  bit [7:0] last0, last1;
  int       line_pulses, frame_pulses;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------------ reference model
  function automatic int pix(input logic [71:0] w, input int r, input int c);
    return int'(w[71 - 8*(3*r + c) -: 8]);
  endfunction

  function automatic int sobel_mag(input logic [71:0] w);
    int kx[3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
    int gx = 0;
    int gy = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        gx += kx[r][c] * pix(w, r, c);
        gy += kx[c][r] * pix(w, r, c);
      end
    return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
  endfunction

  function automatic int expected_px(input logic [71:0] w, input bit blur, input int thr);
    int sum = 0;
    int mag;
    if (blur) begin
      for (int k = 0; k < 9; k++) sum += pix(w, k / 3, k % 3);
      return (sum * 57) / 512;
    end
    mag = sobel_mag(w);
    if (thr == 0) return (mag > 255) ? 255 : mag;
    return (mag >= thr) ? 255 : 0;
  endfunction

  task automatic model_push(input bit v, input logic [71:0] w, input bit m);
    exp_t e;
    bit   eff;
    e = '{default: 0};
    if (v) begin
      eff = (m_in_col == 0) ? m : m_mode;
      if (m_in_col == 0) m_mode = m;
      m_in_col = (m_in_col + 1) % LW;
      e.v  = 1'b1;
      e.p0 = 8'(expected_px(w, eff, 0));
      e.p1 = 8'(expected_px(w, eff, THR1));
      e.ld = (m_out_col == LW - 1);
      e.fd = e.ld && (m_line == LPF - 1);
      m_out_col = (m_out_col + 1) % LW;
      if (e.ld) m_line = (m_line + 1) % LPF;
    end
    q.push_back(e);
  endtask

  function automatic logic [71:0] rand_window();
    logic [71:0] w;
    int kind = $urandom_range(0, 2);
    int base = $urandom_range(0, 240);
    for (int i = 0; i < 9; i++)
      case (kind)
        0:       w[8*i +: 8] = 8'($urandom_range(0, 255));
        1:       w[8*i +: 8] = 8'(base + $urandom_range(0, 15));
        default: w[8*i +: 8] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
      endcase
    return w;
  endfunction

  // ------------------------------------------------------------ stimulus tasks
  // One clock: drive inputs, then compare outputs with the window from 3 edges ago.
  task automatic step(input bit v, input logic [71:0] w, input bit m);
    exp_t e;
    input_pixel_valid = v;
    pixel_window      = w;
    filter_mode       = m;
    model_push(v, w, m);
    @(posedge clk);
    #1;
    if (q.size() > 3) e = q.pop_front();
    else e = '{default: 0};
    if (e.v) begin
      last0 = e.p0;
      last1 = e.p1;
    end
    check("valid", v0, e.v);
    check("valid_thr", v1, e.v);
    check("pixel", px0, last0);
    check("pixel_thr", px1, last1);
    check("line_done", ld0, e.ld);
    check("line_done_thr", ld1, e.ld);
    check("frame_done", fd0, e.fd);
    check("frame_done_thr", fd1, e.fd);
    if (ld0 === 1'b1) line_pulses++;
    if (fd0 === 1'b1) frame_pulses++;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, v0, 0);
    check({tag, "_valid_thr"}, v1, 0);
    check({tag, "_pixel"}, px0, 0);
    check({tag, "_pixel_thr"}, px1, 0);
    check({tag, "_line_done"}, ld0, 0);
    check({tag, "_frame_done"}, fd0, 0);
  endtask

  // Assert reset between edges, check the outputs clear at once, then release.
  task automatic do_reset(input int cycles);
    rst = 1'b0;
    input_pixel_valid = 1'b0;
    q.delete();
    m_in_col = 0; m_out_col = 0; m_line = 0; m_mode = 1'b0;
    last0 = '0; last1 = '0;
    #1;
    check_idle("rst_async");
    repeat (cycles) begin
      @(posedge clk);
      #1;
      check_idle("rst_hold");
    end
    rst = 1'b1;
  endtask

  // Single window followed by three bubbles; the result must appear after edge N+3.
  task automatic directed(input string tag, input logic [71:0] w, input bit m,
                          input int exp0, input int exp1);
    step(1'b1, w, m);
    repeat (3) step(1'b0, '0, m);
    check({tag, "_valid"}, v0, 1);
    check(tag, px0, exp0);
    check({tag, "_thr"}, px1, exp1);
  endtask

  // ------------------------------------------------------------ test sequence
  initial begin
    do_reset(3);

    // Latency: blur of a flat 100 window, first window of the line.
    directed("blur100", {9{8'd100}}, 1'b1, 100, 100);

    // Sobel line; later windows drive filter_mode=1 to show the latch holds.
    do_reset(2);
    directed("vedge", {8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255}, 1'b0, 255, 255);
    directed("flat77", {9{8'd77}}, 1'b1, 0, 0);
    directed("thr30", {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd30, 8'd0, 8'd0, 8'd0}, 1'b1, 60, 0);
    directed("thr40", {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd40, 8'd0, 8'd0, 8'd0}, 1'b1, 80, 255);
    directed("hedge", {{3{8'd0}}, {3{8'd0}}, {3{8'd255}}}, 1'b1, 255, 255);

    // Blur saturation and rounding.
    do_reset(2);
    directed("blur255", {9{8'hFF}}, 1'b1, 255, 255);
    directed("blur9", {8'd9, 64'd0}, 1'b0, 1, 1);

    // Framing: a whole frame with random one-cycle gaps and random modes.
    do_reset(2);
    line_pulses  = 0;
    frame_pulses = 0;
    for (int i = 0; i < LW * LPF; i++) begin
      step(1'b1, rand_window(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) step(1'b0, '0, 1'b0);
    end
    repeat (3) step(1'b0, '0, 1'b0);
    check("line_pulses", line_pulses, LPF);
    check("frame_pulses", frame_pulses, 1);
    for (int i = 0; i < LW + 4; i++) step(1'b1, rand_window(), 1'($urandom_range(0, 1)));
    repeat (3) step(1'b0, '0, 1'b0);

    // Mode latch: toggle mid-line, next line picks up the new mode.
    do_reset(2);
    for (int i = 0; i < LW; i++) step(1'b1, rand_window(), (i < 10) ? 1'b0 : 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, rand_window(), (i < 6) ? 1'b1 : 1'b0);
    check("pre_reset_valid", v0, 1);

    // Reset mid-line: in-flight windows vanish and counting restarts at column 0.
    do_reset(1);
    repeat (2) step(1'b0, '0, 1'b0);
    for (int i = 0; i < LW + 3; i++) step(1'b1, rand_window(), 1'($urandom_range(0, 1)));
    repeat (4) step(1'b0, '0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_window_filter.md
# sobel_window_filter

Pipelined 3x3 window filter directly downstream of the line-buffer window generator. It consumes one 72-bit 3x3 pixel window per valid cycle and produces one 8-bit filtered pixel: either Sobel gradient magnitude (optionally binarised) or a 3x3 box blur. It tracks output position to emit end-of-line and end-of-frame pulses for the DMA/interrupt stage that follows.

## Interface
- LINE_WIDTH, 512, windows per output line
- LINES_PER_FRAME, 510, output lines per frame (image height minus 2)
- THRESHOLD, 0, Sobel binarisation level; 0 disables binarisation
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset; asserting it (low) clears all state immediately
- input_pixel_valid  input  1  window on pixel_window is valid this cycle
- pixel_window  input  72  3x3 window, row-major: [71:64]=p00 (top-left), [63:56]=p01, [55:48]=p02, [47:40]=p10, …, [7:0]=p22
- filter_mode  input  1  0 = Sobel magnitude, 1 = box blur
- output_pixel  output  8  filtered pixel
- output_pixel_valid  output  1  output_pixel valid this cycle
- line_done  output  1  one-cycle pulse with the last pixel of each output line
- frame_done  output  1  one-cycle pulse with the last pixel of the frame

## Operation
- The input is valid-only; there is no backpressure. A window is accepted on every cycle with input_pixel_valid=1. Gaps are allowed anywhere.
- Mode latch:
  - filter_mode is sampled on the first accepted window of each line (input column counter == 0) and held for the rest of that line.
  - The latched mode travels down the pipeline with the data.
- Sobel, computed as signed 11-bit:
  - Gx = (p02 + 2·p12 + p22) − (p00 + 2·p10 + p20)
  - Gy = (p20 + 2·p21 + p22) − (p00 + 2·p01 + p02)
  - mag = |Gx| + |Gy|, range 0..2040, saturated to 255.
  - If THRESHOLD ≠ 0, the output is 255 when mag ≥ THRESHOLD, else 0.
- Blur:
  - sum = Σp, 12-bit, maximum 2295.
  - output = (sum·57) >> 9, 17-bit product. All-255 input gives 255; the result never exceeds 255.
- Pipeline stages, each registered:
  - S1: row/column partial sums (with ×2 terms) and the 12-bit blur sum partials.
  - S2: Gx/Gy differences and absolute values; blur total.
  - S3: magnitude add with saturation and threshold, or blur multiply-shift; then output registers.
- Output column counter (9 bits, 0..LINE_WIDTH−1): increments on each output_pixel_valid. It wraps to 0 after LINE_WIDTH−1, and line_done asserts on that pixel.
- Line counter (9 bits, 0..LINES_PER_FRAME−1): increments on each line_done. It wraps to 0 after the last line, and frame_done asserts together with that line's line_done.
- Input column counter: mirrors the output counter on the input side; used only for the mode latch.

## Timing
- Latency: a window accepted at edge N produces output_pixel_valid=1 after edge N+3. Throughput is one pixel per cycle.
- Valid bits shift through S1→S2→S3 independently of data. Bubbles in the input appear as identical bubbles in the output.
- Reset values: output_pixel=0, output_pixel_valid=0, line_done=0, frame_done=0. All pipeline valids, counters and the latched mode (=0) are cleared.
- Reset mid-operation: in-flight windows are discarded, with no output after release until new input plus 3 cycles. The next output is column 0, line 0.
- output_pixel holds its last value when output_pixel_valid=0.
- line_done and frame_done are high only on a cycle where output_pixel_valid=1.
- A filter_mode change mid-line has no effect until the next line's first window.

## Test plan
- Reset/latency: hold rst low, then release. Outputs are all 0. Drive one valid window of all 100 in blur mode at cycle 0 -> output_pixel=100 with valid exactly 3 cycles later, and valid low otherwise.
- Sobel vertical edge: left column 0, middle 0, right column 255 (p02=p12=p22=255) -> Gx=1020, Gy=0, output 255. Flat window of all 77 -> output 0.
- Threshold: THRESHOLD=64, p12=30, all others 0 -> Gx=60, Gy=0, mag 60 -> output 0. With p12=40 -> mag 80 -> output 255.
- Blur saturation/rounding: all 255 -> 255. Window with sum 9 (one pixel 9, rest 0) -> (9·57)>>9 = 1.
- Framing: stream LINE_WIDTH·LINES_PER_FRAME windows with random one-cycle gaps. line_done pulses exactly 510 times, each on a column-511 pixel. frame_done pulses once on the final pixel. The counters then restart at 0.
- Mode latch and reset mid-line: toggle filter_mode at column 200. The rest of the line uses the original mode and the next line uses the new one. Pulse rst low at column 300 -> valid drops within that cycle, and the next output is column 0.
